hdmi_stream_adapter: RTL

//  Upstream neighbour of hdmi: accepts a valid/ready pixel stream carrying frame/line markers.

---
 rtl/hdmi_pkg.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 67 ++++++
 rtl/hdmi_stream_adapter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared types for the hdmi stream blocks: default pixel format, FIFO entry layout, adapter states.
package hdmi_pkg;

   localparam int unsigned DEFAULT_BPC = 8;
   localparam int unsigned DEFAULT_PW  = 3 * DEFAULT_BPC;

   typedef logic [DEFAULT_PW-1:0] pixel_t;

   typedef struct packed {
      logic   sof;
      logic   eol;
      pixel_t data;
   } fifo_entry_t;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ARMED    = 2'd1,
      LOCKED   = 2'd2
   } adapter_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is always visible on head_c.
module sync_fifo_fwft #(
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned WIDTH = 26,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_c,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    count_next_c
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head_c  = mem[rd_ptr];

   always_comb begin
      count_next_c = count;
      if (push_ok && !pop_ok) begin
         count_next_c = count + CW'(1);
      end else if (!push_ok && pop_ok) begin
         count_next_c = count - CW'(1);
      end
   end

   // Storage carries no reset; validity is tracked by count/empty only.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next_c;
         empty <= (count_next_c == CW'(0));
         full  <= (count_next_c == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/hdmi_stream_adapter.sv
// Buffers a valid/ready pixel stream and serves it to hdmi's pull interface, locking to its frame timing.
module hdmi_stream_adapter
   import hdmi_pkg::*;
#(
   parameter  int unsigned BITS_PER_COLOR = DEFAULT_BPC,
   parameter  int unsigned DEPTH          = 16,
   localparam int unsigned PW             = 3 * BITS_PER_COLOR
) (
   input  logic          clk_pixel,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [PW-1:0] s_data,
   input  logic          s_sof,
   input  logic          s_eol,
   input  logic          i_rd,
   input  logic          i_newline,
   input  logic          i_newframe,
   output logic [PW-1:0] o_pixel,
   output logic          o_locked,
   output logic          o_underflow,
   output logic          o_resync
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = PW + 2;

   typedef struct packed {
      logic          sof;
      logic          eol;
      logic [PW-1:0] data;
   } entry_t;

   adapter_state_t state;
   logic           first_pix;
   entry_t         push_entry;
   entry_t         head;
   logic           push;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  fifo_count;
   logic [CW-1:0]  fifo_count_next;
   logic           unused_c;

   assign push_entry = '{sof: s_sof, eol: s_eol, data: s_data};
   assign push       = s_valid && s_ready;

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk          (clk_pixel),
      .rst_n        (rst),
      .push         (push),
      .push_data    (push_entry),
      .pop          (pop),
      .head_c       (head),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .count        (fifo_count),
      .count_next_c (fifo_count_next)
   );

   // Line-end markers and hdmi line strobes are carried for downstream use only.
   assign unused_c = ^{i_newline, head.eol, fifo_full, fifo_count};

   assign o_pixel = (state == LOCKED && !fifo_empty) ? head.data : '0;

   // Pop decision: drop pre-SOF junk, or consume on an aligned hdmi read.
   always_comb begin
      pop = 1'b0;
      case (state)
         WAIT_SOF: pop = !fifo_empty && !head.sof;
         LOCKED:   pop = !i_newframe && i_rd && !fifo_empty && (first_pix || !head.sof);
         default:  pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk_pixel) begin
      if (!rst) begin
         state       <= WAIT_SOF;
         first_pix   <= 1'b0;
         s_ready     <= 1'b0;
         o_locked    <= 1'b0;
         o_underflow <= 1'b0;
         o_resync    <= 1'b0;
      end else begin
         s_ready     <= (fifo_count_next <= CW'(DEPTH - 2));
         o_underflow <= 1'b0;
         o_resync    <= 1'b0;
         case (state)
            WAIT_SOF: begin
               if (!fifo_empty && head.sof) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (i_newframe) begin
                  state     <= LOCKED;
                  o_locked  <= 1'b1;
                  first_pix <= 1'b1;
               end
            end
            LOCKED: begin
               // i_newframe wins over a same-cycle i_rd.
               if (i_newframe) begin
                  if (!first_pix && (fifo_empty || !head.sof)) begin
                     o_resync <= 1'b1;
                     state    <= WAIT_SOF;
                     o_locked <= 1'b0;
                  end else begin
                     first_pix <= 1'b1;
                  end
               end else if (i_rd) begin
                  if (fifo_empty) begin
                     o_underflow <= 1'b1;
                     first_pix   <= 1'b0;
                  end else if (head.sof && !first_pix) begin
                     o_resync <= 1'b1;
                     state    <= WAIT_SOF;
                     o_locked <= 1'b0;
                  end else begin
                     first_pix <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= WAIT_SOF;
               o_locked <= 1'b0;
            end
         endcase
      end
   end

endmodule
